mul_issue_queue: RTL
====================

// Module: mul_issue_queue
// PURPOSE
//  Data-capture issue queue directly upstream of the MUL unit. Holds dispatched
//  M-extension ops until both source operands are valid, snooping the CDB for them.
//  Issues the oldest ready op through a registered issue stage into the MUL inputs.
//  Entries are killed selectively on mispredict using the ROB flush mask.
// PARAMETERS
//  DEPTH      4                 queue entries (power of 2, >=2)
//  ROB_IDX_W  $clog2(`ROB_LEN)  ROB index width
//  TAG_W      7                 physical register tag width (matches rd)
// PORTS
//  clk              in   1          clock, all state on rising edge
//  rst              in   1          synchronous, active-high reset
//  disp_valid       in   1          dispatch request
//  disp_ready       out  1          queue can accept (count < DEPTH)
//  disp_funct3      in   3          MUL/MULH/MULHSU/MULHU
//  disp_rob_idx     in   ROB_IDX_W  ROB slot of op
//  disp_rd          in   TAG_W      destination tag
//  disp_rs1_tag     in   TAG_W      rs1 source tag
//  disp_rs1_rdy     in   1          rs1 data valid at dispatch
//  disp_rs1_data    in   32         rs1 value (meaningful when rdy)
//  disp_rs2_tag     in   TAG_W      rs2 source tag
//  disp_rs2_rdy     in   1          rs2 data valid at dispatch
//  disp_rs2_data    in   32         rs2 value (meaningful when rdy)
//  cdb_valid        in   1          result broadcast valid
//  cdb_tag          in   TAG_W      broadcast tag
//  cdb_data         in   32         broadcast value
//  mispredict       in   1          branch recovery this cycle
//  flush_mask       in   `ROB_LEN   bit i set => ROB slot i squashed
//  mul_i_valid      out  1          issue valid to MUL
//  mul_i_rob_idx    out  ROB_IDX_W  issued ROB index
//  mul_i_rd         out  TAG_W      issued dest tag
//  funct3           out  3          issued op
//  rs1_data         out  32         issued operand 1
//  rs2_data         out  32         issued operand 2
//  mul_o_ready      in   1          MUL accepts issue this cycle
// BEHAVIOUR
//  Reset: all entry valids 0, count 0, mul_i_valid 0, all other outputs 0.
//  Storage: collapsing queue, slot 0 oldest; removal shifts younger entries down.
//  Dispatch: accepted when disp_valid & disp_ready & !mispredict; written to slot
//   count (after collapse). disp_ready = count<DEPTH from registered state only.
//  Wakeup: entry source with !rdy and tag==cdb_tag while cdb_valid -> rdy=1, data
//   latched. Same-cycle dispatch with matching CDB tag also captures (bypass).
//  Select: oldest valid entry with rs1_rdy & rs2_rdy, from registered state
//   (wakeup in cycle N -> eligible cycle N+1). Issue stage loads it when stage is
//   empty or mul_o_ready; entry leaves queue same edge.
//  Latency: dispatch with both rdy in cycle N -> mul_i_valid in cycle N+2.
//  Stall: mul_i_valid & !mul_o_ready -> issue stage and outputs held stable.
//  Flush: on mispredict, every entry and issue stage with flush_mask[rob_idx]=1 is
//   invalidated at that edge; survivors compact in age order; select suppressed that
//   cycle; dispatch ignored that cycle.
//  Full: count==DEPTH -> disp_ready=0; an issue that cycle frees a slot next cycle.
//  Empty: no eligible entry -> issue stage goes invalid when it drains.
//  Count never exceeds DEPTH; simultaneous dispatch+issue keeps count unchanged.
// TESTING
//  1. rst; dispatch MUL rs1=3,rs2=5 both rdy -> mul_i_valid at +2, data 3/5, rd kept.
//  2. dispatch rs1 tag 9 not rdy; cdb tag 9 data 7 next cycle -> issue rs1_data=7
//     two cycles after broadcast; no issue before.
//  3. fill 4 entries none rdy -> disp_ready=0; wake entry 2 -> issues first, ready=1.
//  4. 3 entries rob 1,2,3; mispredict mask bits 2,3 -> only rob 1 remains/issues.
//  5. hold mul_o_ready=0 with valid issue 3 cycles -> outputs stable, queue unchanged.
//  6. rst asserted mid-stream with 2 entries -> next cycle count 0, mul_i_valid 0.

Source files
------------

// File: rtl/mul_issue_queue_if.sv
// -----------------------------------------------------------------------------
// mul_issue_queue_if
// Purpose : bundles every handshake/bus signal of the MUL issue queue so the
//           dispatch stage, the CDB, branch recovery and the MUL unit connect
//           through one port.
// Ports (signals):
//   dispatch : disp_valid/disp_ready, disp_funct3, disp_rob_idx, disp_rd,
//              disp_rs1_{tag,rdy,data}, disp_rs2_{tag,rdy,data}
//   cdb      : cdb_valid, cdb_tag, cdb_data
//   recovery : mispredict, flush_mask
//   issue    : mul_i_valid, mul_i_rob_idx, mul_i_rd, funct3, rs1_data,
//              rs2_data, mul_o_ready
// Modports : master = the surrounding pipeline, slave = the issue queue.
// -----------------------------------------------------------------------------
`ifndef ROB_LEN
`define ROB_LEN 8
`endif

interface mul_issue_queue_if #(
  parameter int ROB_LEN   = `ROB_LEN,
  parameter int TAG_W     = 7,
  parameter int ROB_IDX_W = $clog2(ROB_LEN)
);
  logic                 disp_valid;
  logic                 disp_ready;
  logic [2:0]           disp_funct3;
  logic [ROB_IDX_W-1:0] disp_rob_idx;
  logic [TAG_W-1:0]     disp_rd;
  logic [TAG_W-1:0]     disp_rs1_tag;
  logic                 disp_rs1_rdy;
  logic [31:0]          disp_rs1_data;
  logic [TAG_W-1:0]     disp_rs2_tag;
  logic                 disp_rs2_rdy;
  logic [31:0]          disp_rs2_data;

  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic [31:0]          cdb_data;

  logic                 mispredict;
  logic [ROB_LEN-1:0]   flush_mask;

  logic                 mul_i_valid;
  logic [ROB_IDX_W-1:0] mul_i_rob_idx;
  logic [TAG_W-1:0]     mul_i_rd;
  logic [2:0]           funct3;
  logic [31:0]          rs1_data;
  logic [31:0]          rs2_data;
  logic                 mul_o_ready;

  modport master (
    output disp_valid, disp_funct3, disp_rob_idx, disp_rd,
           disp_rs1_tag, disp_rs1_rdy, disp_rs1_data,
           disp_rs2_tag, disp_rs2_rdy, disp_rs2_data,
           cdb_valid, cdb_tag, cdb_data, mispredict, flush_mask, mul_o_ready,
    input  disp_ready, mul_i_valid, mul_i_rob_idx, mul_i_rd, funct3,
           rs1_data, rs2_data
  );

  modport slave (
    input  disp_valid, disp_funct3, disp_rob_idx, disp_rd,
           disp_rs1_tag, disp_rs1_rdy, disp_rs1_data,
           disp_rs2_tag, disp_rs2_rdy, disp_rs2_data,
           cdb_valid, cdb_tag, cdb_data, mispredict, flush_mask, mul_o_ready,
    output disp_ready, mul_i_valid, mul_i_rob_idx, mul_i_rd, funct3,
           rs1_data, rs2_data
  );
endinterface

// File: rtl/mul_issue_queue.sv
// -----------------------------------------------------------------------------
// mul_issue_queue
// Purpose : data-capture issue queue feeding the MUL unit. Dispatched M-ext ops
//           wait here until both operands are valid (captured from dispatch or
//           snooped off the CDB), then the oldest ready op moves into a
//           registered issue stage that drives the MUL inputs. Branch recovery
//           squashes entries whose ROB slot is set in flush_mask.
// Ports   :
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous active-high reset
//   io_bus - mul_issue_queue_if.slave: dispatch, CDB, recovery and issue
// -----------------------------------------------------------------------------
`ifndef ROB_LEN
`define ROB_LEN 8
`endif

module mul_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int ROB_LEN   = `ROB_LEN,
  parameter int TAG_W     = 7,
  parameter int ROB_IDX_W = $clog2(ROB_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  mul_issue_queue_if.slave   io_bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]           funct3;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [TAG_W-1:0]     rd;
    logic [TAG_W-1:0]     rs1_tag;
    logic                 rs1_rdy;
    logic [31:0]          rs1_data;
    logic [TAG_W-1:0]     rs2_tag;
    logic                 rs2_rdy;
    logic [31:0]          rs2_data;
  } entry_t;

  // Queue storage: slots 0..r_count-1 are valid, slot 0 is the oldest.
  entry_t               r_ent [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [CNT_W-1:0]     r_count;

  // Issue stage registers driving the MUL inputs.
  logic                 r_iss_valid;
  logic [ROB_IDX_W-1:0] r_iss_rob_idx;
  logic [TAG_W-1:0]     r_iss_rd;
  logic [2:0]           r_iss_funct3;
  logic [31:0]          r_iss_rs1;
  logic [31:0]          r_iss_rs2;

  entry_t               w_woke [DEPTH];
  entry_t               w_next_ent [DEPTH];
  entry_t               w_disp_ent;
  logic [DEPTH-1:0]     w_next_valid;
  logic [CNT_W-1:0]     w_next_count;
  logic [CNT_W-1:0]     w_pos;
  logic                 w_keep;
  logic                 w_disp_ready;
  logic                 w_disp_accept;
  logic                 w_sel_found;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_issue_load;
  logic                 w_iss_kill;

  assign w_disp_ready = (r_count < CNT_W'(DEPTH));

  // CDB snoop on stored entries: only sources still waiting get the data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woke[i] = r_ent[i];
      if (io_bus.cdb_valid && !r_ent[i].rs1_rdy && r_ent[i].rs1_tag == io_bus.cdb_tag) begin
        w_woke[i].rs1_rdy  = 1'b1;
        w_woke[i].rs1_data = io_bus.cdb_data;
      end
      if (io_bus.cdb_valid && !r_ent[i].rs2_rdy && r_ent[i].rs2_tag == io_bus.cdb_tag) begin
        w_woke[i].rs2_rdy  = 1'b1;
        w_woke[i].rs2_data = io_bus.cdb_data;
      end
    end
  end

  // Incoming op, with a same-cycle CDB bypass so a broadcast is never missed.
  always_comb begin
    w_disp_ent          = '0;
    w_disp_ent.funct3   = io_bus.disp_funct3;
    w_disp_ent.rob_idx  = io_bus.disp_rob_idx;
    w_disp_ent.rd       = io_bus.disp_rd;
    w_disp_ent.rs1_tag  = io_bus.disp_rs1_tag;
    w_disp_ent.rs1_rdy  = io_bus.disp_rs1_rdy;
    w_disp_ent.rs1_data = io_bus.disp_rs1_data;
    w_disp_ent.rs2_tag  = io_bus.disp_rs2_tag;
    w_disp_ent.rs2_rdy  = io_bus.disp_rs2_rdy;
    w_disp_ent.rs2_data = io_bus.disp_rs2_data;
    if (io_bus.cdb_valid && !io_bus.disp_rs1_rdy && io_bus.disp_rs1_tag == io_bus.cdb_tag) begin
      w_disp_ent.rs1_rdy  = 1'b1;
      w_disp_ent.rs1_data = io_bus.cdb_data;
    end
    if (io_bus.cdb_valid && !io_bus.disp_rs2_rdy && io_bus.disp_rs2_tag == io_bus.cdb_tag) begin
      w_disp_ent.rs2_rdy  = 1'b1;
      w_disp_ent.rs2_data = io_bus.cdb_data;
    end
  end

  // Oldest-ready select from registered state only, so a wakeup this cycle
  // becomes eligible next cycle. Scanning high to low leaves the lowest index.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && r_ent[i].rs1_rdy && r_ent[i].rs2_rdy) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  assign w_issue_load = w_sel_found && !io_bus.mispredict &&
                        (!r_iss_valid || io_bus.mul_o_ready);
  assign w_disp_accept = io_bus.disp_valid && w_disp_ready && !io_bus.mispredict;
  assign w_iss_kill = io_bus.mispredict && io_bus.flush_mask[r_iss_rob_idx];

  // Collapse: survivors are packed down in age order, then the new op lands
  // in the first free slot behind them.
  always_comb begin
    w_pos        = '0;
    w_keep       = 1'b0;
    w_next_valid = '0;
    for (int j = 0; j < DEPTH; j++) w_next_ent[j] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_keep = r_valid[i];
      if (io_bus.mispredict) begin
        if (io_bus.flush_mask[r_ent[i].rob_idx]) w_keep = 1'b0;
      end else if (w_issue_load && w_sel_idx == IDX_W'(i)) begin
        w_keep = 1'b0;
      end
      if (w_keep) begin
        w_next_ent[w_pos[IDX_W-1:0]]   = w_woke[i];
        w_next_valid[w_pos[IDX_W-1:0]] = 1'b1;
        w_pos = w_pos + CNT_W'(1);
      end
    end
    if (w_disp_accept) begin
      w_next_ent[w_pos[IDX_W-1:0]]   = w_disp_ent;
      w_next_valid[w_pos[IDX_W-1:0]] = 1'b1;
      w_pos = w_pos + CNT_W'(1);
    end
    w_next_count = w_pos;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      r_valid <= w_next_valid;
      r_count <= w_next_count;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_next_ent[i];
    end
  end

  // Issue stage: reload when free or being consumed; otherwise hold under
  // stall, drop when consumed or squashed. Data is kept when it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid   <= 1'b0;
      r_iss_rob_idx <= '0;
      r_iss_rd      <= '0;
      r_iss_funct3  <= '0;
      r_iss_rs1     <= '0;
      r_iss_rs2     <= '0;
    end else if (w_issue_load) begin
      r_iss_valid   <= 1'b1;
      r_iss_rob_idx <= r_ent[w_sel_idx].rob_idx;
      r_iss_rd      <= r_ent[w_sel_idx].rd;
      r_iss_funct3  <= r_ent[w_sel_idx].funct3;
      r_iss_rs1     <= r_ent[w_sel_idx].rs1_data;
      r_iss_rs2     <= r_ent[w_sel_idx].rs2_data;
    end else if (r_iss_valid && (w_iss_kill || io_bus.mul_o_ready)) begin
      r_iss_valid   <= 1'b0;
    end
  end

  assign io_bus.disp_ready    = w_disp_ready;
  assign io_bus.mul_i_valid   = r_iss_valid;
  assign io_bus.mul_i_rob_idx = r_iss_rob_idx;
  assign io_bus.mul_i_rd      = r_iss_rd;
  assign io_bus.funct3        = r_iss_funct3;
  assign io_bus.rs1_data      = r_iss_rs1;
  assign io_bus.rs2_data      = r_iss_rs2;

endmodule
